// File: rtl/msgpass_rd_sched_pkg.sv
// Configuration packages for the message-pass read scheduler.
// memShare_config_pkg holds the DRC flag count from memShare control.
// msgPass_config_pkg holds the buffer geometry, read latency and FSM state type.
package memShare_config_pkg;
  localparam int MEMSHARE_DRC_NUM = 4;
endpackage

package msgPass_config_pkg;
  localparam int MSGPASS_BUFF_DEPTH      = 16;
  localparam int MSGPASS_BUFF_ADDR_WIDTH = 4;
  localparam int MSGPASS_BUFF_RD_LATENCY = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    DRC_HOLD = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } msgpass_rd_sched_state_e;
endpackage

// File: rtl/msgpass_rd_sched_if.sv
// Request/status bundle between a burst requester (master) and the read
// scheduler (slave). The master issues start/abort and feeds the DRC flags.
interface msgpass_rd_sched_if #(
  parameter int ADDR_W  = msgPass_config_pkg::MSGPASS_BUFF_ADDR_WIDTH,
  parameter int DRC_NUM = memShare_config_pkg::MEMSHARE_DRC_NUM
);
  logic               start_i;
  logic               abort_i;
  logic [ADDR_W-1:0]  base_addr_i;
  logic [ADDR_W:0]    rqst_num_i;
  logic [DRC_NUM-1:0] is_drc_i;
  logic [ADDR_W-1:0]  raddr_o;
  logic               rd_valid_o;
  logic               scu_busy_o;
  logic               done_o;
  logic [7:0]         drc_stall_cnt_o;

  modport master (
    output start_i, abort_i, base_addr_i, rqst_num_i, is_drc_i,
    input  raddr_o, rd_valid_o, scu_busy_o, done_o, drc_stall_cnt_o
  );

  modport slave (
    input  start_i, abort_i, base_addr_i, rqst_num_i, is_drc_i,
    output raddr_o, rd_valid_o, scu_busy_o, done_o, drc_stall_cnt_o
  );
endinterface

// File: rtl/msgpass_rd_addr_cnt.sv
// Read address / remaining-entry counter for one burst.
// load captures base and length; advance steps the address (wrapping at
// DEPTH-1 back to 0) and consumes one entry.
module msgpass_rd_addr_cnt #(
  parameter int ADDR_W = msgPass_config_pkg::MSGPASS_BUFF_ADDR_WIDTH,
  parameter int DEPTH  = msgPass_config_pkg::MSGPASS_BUFF_DEPTH
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [ADDR_W:0]   loadNum,
  output logic [ADDR_W-1:0] addr,
  output logic              isLast
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W:0] remaining;

  assign isLast = (remaining == (ADDR_W+1)'(1));

  // Load on burst start, otherwise step once per accepted issue.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= loadAddr;
      remaining <= loadNum;
    end else if (advance) begin
      addr      <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
      remaining <= remaining - (ADDR_W+1)'(1);
    end
  end
endmodule

// File: rtl/msgpass_rd_sched.sv
// Message-pass buffer read scheduler: walks a burst of buffer addresses,
// holding and re-issuing while memShare reports a DRC conflict, and flags
// each read's data one buffer latency later.
// Optional macro MSGPASS_RD_SCHED_PERF_CNT_EN enables the DRC stall counter;
// without it drc_stall_cnt_o is tied to 0.
module msgpass_rd_sched
  import msgPass_config_pkg::*;
#(
  parameter int ADDR_W  = msgPass_config_pkg::MSGPASS_BUFF_ADDR_WIDTH,
  parameter int DEPTH   = msgPass_config_pkg::MSGPASS_BUFF_DEPTH,
  parameter int DRC_NUM = memShare_config_pkg::MEMSHARE_DRC_NUM
) (
  input  logic               sys_clk,
  input  logic               rst,
  msgpass_rd_sched_if.slave  bus
);
  localparam int LAT = MSGPASS_BUFF_RD_LATENCY;

  msgpass_rd_sched_state_e state, stateNxt;

  logic [DRC_NUM-1:0] drcFlags;
  logic               anyDrc;
  logic               startOk;
  logic               loadBurst;
  logic               accept;
  logic               isLast;
  logic [LAT-1:0]     vldPipe;

  assign drcFlags  = bus.is_drc_i;
  assign anyDrc    = |drcFlags;
  // Abort dominates a simultaneous start.
  assign startOk   = (state == IDLE) && bus.start_i && !bus.abort_i;
  assign loadBurst = startOk && (bus.rqst_num_i != '0);
  // An issue only counts when memShare reports no conflict.
  assign accept    = (state == ISSUE) && !anyDrc && !bus.abort_i;

  msgpass_rd_addr_cnt #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) uAddrCnt (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .load     (loadBurst),
    .advance  (accept),
    .loadAddr (bus.base_addr_i),
    .loadNum  (bus.rqst_num_i),
    .addr     (bus.raddr_o),
    .isLast   (isLast)
  );

  // Next-state selection; abort returns to IDLE from anywhere.
  always_comb begin
    stateNxt = state;
    if (bus.abort_i) begin
      stateNxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (bus.start_i) stateNxt = (bus.rqst_num_i == '0) ? DONE : ISSUE;
        ISSUE:    if (anyDrc) stateNxt = DRC_HOLD;
                  else if (isLast) stateNxt = DRAIN;
        DRC_HOLD: if (!anyDrc) stateNxt = ISSUE;
        DRAIN:    stateNxt = DONE;
        DONE:     stateNxt = IDLE;
        default:  stateNxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // Accepted-issue flag delayed by the buffer read latency; cleared on abort
  // so no stale valid escapes a cancelled burst.
  always_ff @(posedge sys_clk) begin
    if (rst || bus.abort_i) begin
      vldPipe <= '0;
    end else begin
      vldPipe[0] <= accept;
      for (int i = 1; i < LAT; i++) vldPipe[i] <= vldPipe[i-1];
    end
  end

  assign bus.rd_valid_o = vldPipe[LAT-1];
  assign bus.scu_busy_o = (state == ISSUE) || (state == DRC_HOLD) || (state == DRAIN);
  assign bus.done_o     = (state == DONE);

`ifdef MSGPASS_RD_SCHED_PERF_CNT_EN
  logic [7:0] drcStallCnt;

  // Saturating count of DRC hold cycles, restarted by each accepted start.
  always_ff @(posedge sys_clk) begin
    if (rst || startOk)
      drcStallCnt <= '0;
    else if ((state == DRC_HOLD) && (drcStallCnt != 8'hFF))
      drcStallCnt <= drcStallCnt + 8'd1;
  end

  assign bus.drc_stall_cnt_o = drcStallCnt;
`else
  assign bus.drc_stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_msgpass_rd_sched.sv
// Directed bench for msgpass_rd_sched: bursts, address wrap, DRC hold,
// zero-length request, abort, start-during-burst and mid-burst reset.
module tb_msgpass_rd_sched;
  import msgPass_config_pkg::*;

  localparam int ADDR_W  = MSGPASS_BUFF_ADDR_WIDTH;
  localparam int DEPTH   = MSGPASS_BUFF_DEPTH;
  localparam int DRC_NUM = memShare_config_pkg::MEMSHARE_DRC_NUM;
`ifdef MSGPASS_RD_SCHED_PERF_CNT_EN
  localparam int EXP_STALL = 3;
`else
  localparam int EXP_STALL = 0;
`endif

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  msgpass_rd_sched_if #(.ADDR_W(ADDR_W), .DRC_NUM(DRC_NUM)) bus ();

  msgpass_rd_sched #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .DRC_NUM (DRC_NUM)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkOut(input string tag, input int vld, input int busy, input int done);
    chk({tag, "_vld"},  32'(bus.rd_valid_o), 32'(vld));
    chk({tag, "_busy"}, 32'(bus.scu_busy_o), 32'(busy));
    chk({tag, "_done"}, 32'(bus.done_o),     32'(done));
  endtask

  task automatic startBurst(input int base, input int num);
    bus.start_i     = 1'b1;
    bus.base_addr_i = ADDR_W'(base);
    bus.rqst_num_i  = (ADDR_W+1)'(num);
    tick();
    bus.start_i     = 1'b0;
  endtask

  initial begin
    int t2Addr [4];
    t2Addr = '{DEPTH-2, DEPTH-1, 0, 1};
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.base_addr_i = '0;
    bus.rqst_num_i = '0;
    bus.is_drc_i = '0;

    // Reset state
    tick(); tick();
    chk("rst_addr", 32'(bus.raddr_o), 0);
    chkOut("rst", 0, 0, 0);
    chk("rst_cnt", 32'(bus.drc_stall_cnt_o), 0);
    rst = 1'b0;
    tick();

    // base=0, num=5, no DRC
    startBurst(0, 5);
    for (int i = 0; i < 5; i++) begin
      chk("t1_addr", 32'(bus.raddr_o), 32'(i));
      chkOut("t1_issue", (i != 0) ? 1 : 0, 1, 0);
      tick();
    end
    chkOut("t1_drain", 1, 1, 0);
    tick();
    chkOut("t1_done", 0, 0, 1);
    tick();
    chkOut("t1_idle", 0, 0, 0);

    // Wrap: base=DEPTH-2, num=4; a start mid-burst must be ignored
    startBurst(DEPTH-2, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", 32'(bus.raddr_o), 32'(t2Addr[i]));
      chk("t2_busy", 32'(bus.scu_busy_o), 1);
      if (i == 1) begin
        bus.start_i = 1'b1; bus.base_addr_i = ADDR_W'(7); bus.rqst_num_i = (ADDR_W+1)'(2);
      end
      tick();
      bus.start_i = 1'b0;
    end
    chkOut("t2_drain", 1, 1, 0);
    tick();
    chkOut("t2_done", 0, 0, 1);
    tick();

    // DRC hold for 3 cycles at address 2
    startBurst(0, 5);
    tick(); tick();
    chk("t3_pre_addr", 32'(bus.raddr_o), 2);
    chk("t3_pre_vld", 32'(bus.rd_valid_o), 1);
    bus.is_drc_i = DRC_NUM'(2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_addr", 32'(bus.raddr_o), 2);
      chkOut("t3_hold", 0, 1, 0);
    end
    bus.is_drc_i = '0;
    tick();
    chk("t3_reissue_addr", 32'(bus.raddr_o), 2);
    chk("t3_reissue_vld", 32'(bus.rd_valid_o), 0);
    chk("t3_stall_cnt", 32'(bus.drc_stall_cnt_o), 32'(EXP_STALL));
    tick();
    chk("t3_after_addr", 32'(bus.raddr_o), 3);
    chk("t3_after_vld", 32'(bus.rd_valid_o), 1);
    tick(); tick();
    chkOut("t3_drain", 1, 1, 0);
    tick();
    chkOut("t3_done", 0, 0, 1);
    chk("t3_cnt_hold", 32'(bus.drc_stall_cnt_o), 32'(EXP_STALL));
    tick();

    // Zero-length request
    startBurst(3, 0);
    chkOut("t4_done", 0, 0, 1);
    tick();
    chkOut("t4_idle", 0, 0, 0);

    // Abort at the third issue of num=8
    startBurst(0, 8);
    tick(); tick();
    chk("t5_pre_addr", 32'(bus.raddr_o), 2);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chkOut("t5_abort", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chkOut("t5_after", 0, 0, 0);
    end

    // Abort wins over start in IDLE
    bus.abort_i = 1'b1;
    startBurst(0, 3);
    bus.abort_i = 1'b0;
    chkOut("t6_abort_start", 0, 0, 0);
    tick();
    chkOut("t6_abort_start2", 0, 0, 0);

    // Reset mid-burst, then start base=4, num=2 straight away
    startBurst(0, 8);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("t7_rst_addr", 32'(bus.raddr_o), 0);
    chkOut("t7_rst", 0, 0, 0);
    chk("t7_rst_cnt", 32'(bus.drc_stall_cnt_o), 0);
    rst = 1'b0;
    startBurst(4, 2);
    chk("t7_addr0", 32'(bus.raddr_o), 4);
    chkOut("t7_issue0", 0, 1, 0);
    tick();
    chk("t7_addr1", 32'(bus.raddr_o), 5);
    chkOut("t7_issue1", 1, 1, 0);
    tick();
    chkOut("t7_drain", 1, 1, 0);
    tick();
    chkOut("t7_done", 0, 0, 1);
    tick();
    chkOut("t7_idle", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
